// File: rtl/ifu.sv
// rtl/ifu.sv - two-stage instruction fetch unit (pre-IF request, IF hold/buffer)
module ifu (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        IDU_br_taken,
  input  logic        IDU_br_taken_cancel,
  input  logic [31:0] IDU_br_target,
  input  logic        IDU_allow_in,
  output logic        IFU_to_IDU_valid,
  output logic [31:0] pc_from_IFU,
  output logic [31:0] inst_from_IFU
);

  localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

  logic        preif_valid;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        resp_valid;
  logic        inst_buf_valid;
  logic [31:0] inst_buf;

  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_allow_in;
  logic        to_id_fire;
  logic        buf_capture;

  // A held branch needs no action here: ID keeps allow_in low until the cancel resolves it.
  logic unused_br_taken;
  assign unused_br_taken = IDU_br_taken;

  assign nextpc      = IDU_br_taken_cancel ? IDU_br_target : fs_pc + 32'h4;
  assign fs_ready_go = fs_valid && (resp_valid || inst_buf_valid);
  assign fs_allow_in = !fs_valid || (fs_ready_go && IDU_allow_in);

  assign inst_sram_en    = resetn && preif_valid && (fs_allow_in || IDU_br_taken_cancel);
  assign inst_sram_we    = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  assign IFU_to_IDU_valid = resetn && fs_valid && fs_ready_go && !IDU_br_taken_cancel;
  assign pc_from_IFU      = fs_pc;
  assign inst_from_IFU    = inst_buf_valid ? inst_buf : inst_sram_rdata;

  assign to_id_fire  = IFU_to_IDU_valid && IDU_allow_in;
  // The SRAM word is only on the bus for one cycle, so keep it if ID stalls.
  assign buf_capture = fs_valid && resp_valid && !inst_buf_valid && !IDU_allow_in
                       && !IDU_br_taken_cancel;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      preif_valid    <= 1'b0;
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC;
      resp_valid     <= 1'b0;
      inst_buf_valid <= 1'b0;
      inst_buf       <= 32'h0;
    end else begin
      preif_valid <= 1'b1;
      resp_valid  <= inst_sram_en;
      if (inst_sram_en) begin
        fs_valid <= 1'b1;
        fs_pc    <= nextpc;
      end
      if (IDU_br_taken_cancel || to_id_fire) begin
        inst_buf_valid <= 1'b0;
      end else if (buf_capture) begin
        inst_buf_valid <= 1'b1;
        inst_buf       <= inst_sram_rdata;
      end
    end
  end

endmodule
